// File: rtl/jstk_spi_master.sv
// SPI mode-0 master that polls a joystick: sends one LED command byte plus four pad bytes,
// and returns the X/Y position and button states from the five bytes it receives.
module jstk_spi_master #(
    parameter int GAP_TICKS = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CLKDIV,
    input  logic       START,
    input  logic [1:0] LED,
    input  logic       MISO,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    output logic       BUSY,
    output logic       DONE,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic [2:0] BTN
);

    // state  | meaning
    // IDLE   | SS high, waiting for START
    // SETUP  | SS low, MOSI holds bit 7, wait one tick
    // XFER   | two ticks per bit: rising samples MISO, falling shifts MOSI
    // GAP    | idle ticks between bytes
    // FINISH | one tick after the last byte, then publish results
    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, FINISH} state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS - 1);

    state_t     state;
    logic       clkdiv_q;
    logic       tick;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [3:0] bit_cnt;
    logic [2:0] byte_idx;
    logic [7:0] gap_cnt;
    logic [7:0] rx0;
    logic [1:0] rx1;
    logic [7:0] rx2;
    logic [1:0] rx3;
    logic [2:0] rx4;

    assign tick = CLKDIV & ~clkdiv_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            clkdiv_q <= 1'b1;
            SS       <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            X        <= '0;
            Y        <= '0;
            BTN      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            rx0      <= '0;
            rx1      <= '0;
            rx2      <= '0;
            rx3      <= '0;
            rx4      <= '0;
        end else begin
            clkdiv_q <= CLKDIV;
            DONE     <= 1'b0;
            case (state)
                IDLE: begin
                    SS   <= 1'b1;
                    SCLK <= 1'b0;
                    BUSY <= 1'b0;
                    if (START) begin
                        tx_sh    <= {6'b100000, LED};
                        MOSI     <= 1'b1;
                        SS       <= 1'b0;
                        BUSY     <= 1'b1;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) state <= XFER;
                end
                XFER: begin
                    if (tick) begin
                        if (!SCLK) begin
                            SCLK    <= 1'b1;
                            rx_sh   <= {rx_sh[6:0], MISO};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            SCLK <= 1'b0;
                            if (bit_cnt < 4'd8) begin
                                MOSI  <= tx_sh[6];
                                tx_sh <= {tx_sh[6:0], 1'b0};
                            end else begin
                                bit_cnt <= '0;
                                case (byte_idx)
                                    3'd0:    rx0 <= rx_sh;
                                    3'd1:    rx1 <= rx_sh[1:0];
                                    3'd2:    rx2 <= rx_sh;
                                    3'd3:    rx3 <= rx_sh[1:0];
                                    default: rx4 <= rx_sh[2:0];
                                endcase
                                if (byte_idx == 3'd4) begin
                                    state <= FINISH;
                                end else if (GAP_TICKS == 0) begin
                                    // no gap: next pad byte loads on this same falling tick
                                    byte_idx <= byte_idx + 3'd1;
                                    tx_sh    <= 8'h00;
                                    MOSI     <= 1'b0;
                                end else begin
                                    gap_cnt <= GAP_LOAD;
                                    state   <= GAP;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == 8'd0) begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_sh    <= 8'h00;
                            MOSI     <= 1'b0;
                            state    <= XFER;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                end
                FINISH: begin
                    if (tick) begin
                        SS    <= 1'b1;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        X     <= {rx1, rx0};
                        Y     <= {rx3, rx2};
                        BTN   <= rx4;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_master.sv
// Directed bench for jstk_spi_master: default build and a GAP_TICKS=0 build run side by side,
// each with its own joystick MISO model and bus-timing monitor.
module tb_jstk_spi_master;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CLKDIV = 1'b0;
    logic       START = 1'b0;
    logic [1:0] LED = 2'b00;
    logic [1:0] miso = 2'b00;
    logic [1:0] ss, sclk, mosi, busy, done;
    logic [9:0] x [2];
    logic [9:0] y [2];
    logic [2:0] btn [2];

    int checks = 0;
    int errors = 0;

    jstk_spi_master dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .CLKDIV(CLKDIV), .START(START), .LED(LED),
        .MISO(miso[0]), .SS(ss[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .BUSY(busy[0]),
        .DONE(done[0]), .X(x[0]), .Y(y[0]), .BTN(btn[0])
    );

    jstk_spi_master #(.GAP_TICKS(0)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .CLKDIV(CLKDIV), .START(START), .LED(LED),
        .MISO(miso[1]), .SS(ss[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .BUSY(busy[1]),
        .DONE(done[1]), .X(x[1]), .Y(y[1]), .BTN(btn[1])
    );

    always #5 CLK = ~CLK;

    // divided clock: 2 CLK high, 2 CLK low, or held at clkdiv_hold
    bit         clkdiv_run = 1'b1;
    logic       clkdiv_hold = 1'b0;
    logic [1:0] div_cnt = 2'd0;
    initial forever begin
        @(posedge CLK);
        #1;
        if (clkdiv_run) begin
            div_cnt = div_cnt + 2'd1;
            CLKDIV  = div_cnt[1];
        end else begin
            CLKDIV = clkdiv_hold;
        end
    end

    logic [39:0] miso_stream = {8'h34, 8'h02, 8'hCD, 8'h01, 8'h05};
    int          rise_cnt [2]   = '{0, 0};
    int          tick_cnt [2]   = '{0, 0};
    int          last_ticks [2] = '{0, 0};
    int          last_rises [2] = '{0, 0};
    int          done_cnt [2]   = '{0, 0};
    int          viol [2]       = '{0, 0};
    logic [39:0] mosi_sh [2]    = '{40'd0, 40'd0};
    logic        prev_ss [2]    = '{1'b1, 1'b1};
    logic        prev_sclk [2]  = '{1'b0, 1'b0};
    logic        prev_mosi [2]  = '{1'b0, 1'b0};
    logic        prev_done [2]  = '{1'b0, 1'b0};
    logic        clkdiv_prev    = 1'b0;

    always @(negedge CLK) begin
        logic tk;
        tk = CLKDIV & ~clkdiv_prev;
        for (int i = 0; i < 2; i++) begin
            if (prev_ss[i] && !ss[i]) begin
                rise_cnt[i] = 0;
                tick_cnt[i] = 0;
                mosi_sh[i]  = '0;
            end
            if (!ss[i] && tk) tick_cnt[i]++;
            if (!prev_ss[i] && ss[i]) begin
                last_ticks[i] = tick_cnt[i];
                last_rises[i] = rise_cnt[i];
            end
            if (!prev_sclk[i] && sclk[i]) begin
                rise_cnt[i]++;
                mosi_sh[i] = {mosi_sh[i][38:0], mosi[i]};
                if (mosi[i] !== prev_mosi[i]) viol[i]++;
            end
            if (prev_sclk[i] && sclk[i] && (mosi[i] !== prev_mosi[i])) viol[i]++;
            if (ss[i] && sclk[i]) viol[i]++;
            if (done[i]) begin
                done_cnt[i]++;
                if (prev_done[i]) viol[i]++;
            end
            miso[i]      = (rise_cnt[i] < 40) ? miso_stream[39 - rise_cnt[i]] : 1'b0;
            prev_ss[i]   = ss[i];
            prev_sclk[i] = sclk[i];
            prev_mosi[i] = mosi[i];
            prev_done[i] = done[i];
        end
        clkdiv_prev = CLKDIV;
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_both_done(input int budget);
        for (int n = 0; n < budget && !(done_cnt[0] >= 1 && done_cnt[1] >= 1); n++) begin
            @(negedge CLK);
            #1;
        end
        check("done0_seen", 40'(done_cnt[0] >= 1), 40'd1);
        check("done1_seen", 40'(done_cnt[1] >= 1), 40'd1);
    endtask

    initial begin
        LED = 2'b01;
        repeat (4) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check("rst_ss",   40'(ss[i]),   40'd1);
            check("rst_sclk", 40'(sclk[i]), 40'd0);
            check("rst_mosi", 40'(mosi[i]), 40'd0);
            check("rst_busy", 40'(busy[i]), 40'd0);
            check("rst_done", 40'(done[i]), 40'd0);
            check("rst_x",    40'(x[i]),    40'd0);
            check("rst_y",    40'(y[i]),    40'd0);
            check("rst_btn",  40'(btn[i]),  40'd0);
        end
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);

        // abort in byte 2, bit 3
        pulse_start();
        for (int n = 0; n < 2000 && rise_cnt[0] != 19; n++) begin
            @(negedge CLK);
            #1;
        end
        check("midbyte_reach", 40'(rise_cnt[0]), 40'd19);
        RESET_N = 1'b0;
        #1;
        check("abort_ss",   40'(ss[0]),   40'd1);
        check("abort_sclk", 40'(sclk[0]), 40'd0);
        check("abort_busy", 40'(busy[0]), 40'd0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (500) @(negedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("abort_nodone", 40'(done_cnt[i]), 40'd0);
            check("abort_x",      40'(x[i]),        40'd0);
            check("abort_y",      40'(y[i]),        40'd0);
            check("abort_btn",    40'(btn[i]),      40'd0);
        end

        // basic read
        done_cnt = '{0, 0};
        viol     = '{0, 0};
        pulse_start();
        wait_both_done(3000);
        repeat (20) @(negedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("basic_x",     40'(x[i]),          40'h234);
            check("basic_y",     40'(y[i]),          40'h1CD);
            check("basic_btn",   40'(btn[i]),        40'd5);
            check("basic_mosi",  mosi_sh[i],         {8'h81, 32'h0});
            check("basic_ticks", 40'(last_ticks[i]), (i == 0) ? 40'd90 : 40'd82);
            check("basic_rises", 40'(last_rises[i]), 40'd40);
            check("basic_ndone", 40'(done_cnt[i]),   40'd1);
        end

        // START held through the transaction
        LED      = 2'b10;
        done_cnt = '{0, 0};
        @(negedge CLK);
        START = 1'b1;
        for (int n = 0; n < 3000 && !done[0]; n++) begin
            @(negedge CLK);
            #1;
        end
        check("hold_done",   40'(done[0]),       40'd1);
        check("hold_ss_hi",  40'(ss[0]),         40'd1);
        check("hold_busy0",  40'(busy[0]),       40'd0);
        check("hold_ndone",  40'(done_cnt[0]),   40'd1);
        check("hold_ticks",  40'(last_ticks[0]), 40'd90);
        check("hold_mosi",   mosi_sh[0],         {8'h82, 32'h0});
        @(negedge CLK);
        check("hold_restart_ss",   40'(ss[0]),   40'd0);
        check("hold_restart_busy", 40'(busy[0]), 40'd1);
        START = 1'b0;
        for (int n = 0; n < 3000 && busy != 2'b00; n++) @(negedge CLK);
        check("hold_idle", 40'(busy), 40'd0);
        check("hold_x",    40'(x[0]), 40'h234);

        // reset released while CLKDIV sits high
        clkdiv_hold = 1'b1;
        clkdiv_run  = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b0;
        START   = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        #1;
        check("held_ss",    40'(ss[0]),       40'd0);
        check("held_busy",  40'(busy[0]),     40'd1);
        check("held_sclk",  40'(sclk[0]),     40'd0);
        check("held_rises", 40'(rise_cnt[0]), 40'd0);
        START      = 1'b0;
        done_cnt   = '{0, 0};
        clkdiv_run = 1'b1;
        wait_both_done(3000);
        for (int i = 0; i < 2; i++) begin
            check("held_ticks", 40'(last_ticks[i]), (i == 0) ? 40'd90 : 40'd82);
            check("held_nrise", 40'(last_rises[i]), 40'd40);
            check("held_mosi",  mosi_sh[i],         {8'h82, 32'h0});
            check("held_y",     40'(y[i]),          40'h1CD);
            check("timing",     40'(viol[i]),       40'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jstk_spi_master.md
JSTK_SPI_MASTER -- requirements
Module: jstk_spi_master

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: 100 MHz system clock; the only clock.
- RESET_N, in, 1: asynchronous, active-low reset.
- CLKDIV, in, 1: divided serial clock, synchronous to CLK; every rising edge is one "tick".
- START, in, 1: level request to begin a transaction.
- LED, in, 2: LED command bits sent in byte 0.
- MISO, in, 1: serial data from the joystick.
- SS, out, 1: slave select, active-low.
- SCLK, out, 1: SPI clock, mode 0 (idle low).
- MOSI, out, 1: serial data to the joystick.
- BUSY, out, 1: transaction in progress.
- DONE, out, 1: one-CLK pulse when a transaction completes.
- X, out, 10: joystick X position.
- Y, out, 10: joystick Y position.
- BTN, out, 3: button states.

REQ-002 SHALL have one parameter, GAP_TICKS, default 2: the number of idle ticks between bytes.

Function
REQ-003 SHALL detect ticks by registering CLKDIV in CLK and flagging tick = CLKDIV & ~CLKDIV_q; the tick lasts exactly one CLK cycle.
REQ-004 SHALL implement states IDLE, SETUP, XFER, GAP, FINISH; all state changes other than IDLE->SETUP occur only on tick cycles.
REQ-005 In IDLE: SS=1, SCLK=0, BUSY=0. When START=1, on the next CLK: load tx byte 0, SS<=0, MOSI<=tx[7], BUSY<=1, byte_idx<=0, bit_cnt<=0, go to SETUP.
REQ-006 START SHALL be ignored outside IDLE; no queuing.
REQ-007 SETUP SHALL wait one tick, then go to XFER with SCLK still 0.
REQ-008 In XFER, a tick with SCLK=0 SHALL do: SCLK<=1; rx<={rx[6:0],MISO}; bit_cnt<=bit_cnt+1.
REQ-009 In XFER, a tick with SCLK=1 SHALL do: SCLK<=0; if bit_cnt<8, MOSI<=next tx bit (MSB first); else store rx into rx_byte[byte_idx], bit_cnt<=0.
- If byte_idx<4: go to GAP.
- If byte_idx==4: go to FINISH.
REQ-010 GAP SHALL count GAP_TICKS ticks, then: byte_idx<=byte_idx+1, load the next tx byte, MOSI<=its bit 7, return to XFER.
REQ-011 Tx bytes SHALL be: byte 0 = {6'b100000, LED[1:0]} (LED sampled at START acceptance); bytes 1-4 = 8'h00.
REQ-012 FINISH SHALL wait one tick, then in one CLK cycle:
- SS<=1, BUSY<=0, DONE<=1.
- X<={rx1[1:0],rx0}, Y<={rx3[1:0],rx2}, BTN<=rx4[2:0].
- Go to IDLE.
REQ-013 DONE SHALL deassert on the following CLK.
REQ-014 X, Y, BTN SHALL change only in the FINISH completion cycle and hold otherwise.
REQ-015 Transaction length SHALL be exactly 1 + 5*16 + 4*GAP_TICKS + 1 ticks (90 ticks at default).
REQ-016 SCLK SHALL toggle only while SS=0; MOSI SHALL change only on SCLK falling ticks or on byte loads.
REQ-017 If START=1 in the same cycle as DONE, the block SHALL return to IDLE first; the new transaction starts on the next CLK if START is still 1.

Reset
REQ-018 RESET_N=0 SHALL asynchronously force:
- state=IDLE, SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0.
- X=0, Y=0, BTN=0, counters=0, CLKDIV_q=1.
REQ-019 Reset mid-transaction SHALL abort it immediately, with no DONE and no output update.
REQ-020 After reset release, no tick SHALL be flagged until CLKDIV makes a genuine 0->1 transition.

Verification
REQ-021 Directed bench scenarios (stimulus -> required response):
- Basic read: LED=2'b01; MISO model returns bytes 0x34,0x02,0xCD,0x01,0x05; pulse START -> MOSI byte 0 = 0x81, bytes 1-4 = 0x00; X=0x234, Y=0x1CD, BTN=3'b101; one DONE pulse; exactly 90 ticks from SS fall to SS rise.
- Mode-0 timing: check every SCLK rising edge -> MOSI stable since the prior falling tick; exactly 40 SCLK rising edges per transaction; SCLK=0 whenever SS=1.
- START while BUSY: hold START high through the transaction -> no restart mid-transfer; second transaction SS falls 1 CLK after DONE.
- Reset mid-byte: assert RESET_N=0 at byte 2, bit 3 -> SS=1, SCLK=0, BUSY=0 in the same cycle; X/Y/BTN stay 0; no DONE.
- GAP_TICKS=0 build: full transaction -> 82 ticks total; data correct.
- Reset release with CLKDIV=1 held -> no SCLK activity until the first genuine rising edge after a START.
